// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
// State encoding, default geometry, wait-counter width and the
// address legality helper used when DMEM_ADDR_CHECK_EN is defined.
package dmem_pkg;

   localparam int DMEM_ADDR_W = 5;
   localparam int DMEM_DATA_W = 32;
   localparam int CTR_W       = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // True when a byte address is not word aligned or lies beyond the array.
   function automatic logic addr_out_of_range(input logic [31:0] addr,
                                              input int          addr_w);
      return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
   endfunction

endpackage

// File: rtl/dmem_wait_ctr.sv
// dmem_wait_ctr: loadable down-counter with a zero flag, used to time the
// wait states between request accept and response.
module dmem_wait_ctr
   import dmem_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CTR_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CTR_W-1:0] count;

   // Load has priority over decrement; the counter saturates at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CTR_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: synthesizable data-memory responder with programmable
// wait states, req/ready handshake and a backdoor debug port.
// Optional build macro DMEM_ADDR_CHECK_EN adds mem_err and blocks accesses
// to misaligned or out-of-range byte addresses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = DMEM_ADDR_W,
   parameter int DATA_W      = DMEM_DATA_W,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_req,
   input  logic              mem_wen,
   input  logic [31:0]       mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ready,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
`ifdef DMEM_ADDR_CHECK_EN
   output logic              mem_err,
`endif
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [CTR_W-1:0] WAIT_LOAD =
      CTR_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] lat_idx;
   logic              lat_wen;
   logic [DATA_W-1:0] lat_wdata;

   logic [ADDR_W-1:0] acc_idx;
   logic              acc_wen;
   logic [DATA_W-1:0] acc_wdata;
   logic              acc_err;
   logic              accept;
   logic              commit;
   logic              ctr_zero;

   // With zero wait states the access commits on the accept edge itself, so
   // the access operands come straight from the port while in IDLE.
   assign accept    = (state == IDLE) && mem_req;
   assign acc_idx   = (state == IDLE) ? mem_addr[ADDR_W+1:2] : lat_idx;
   assign acc_wen   = (state == IDLE) ? mem_wen : lat_wen;
   assign acc_wdata = (state == IDLE) ? mem_wdata : lat_wdata;
   assign commit    = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && ctr_zero);

`ifdef DMEM_ADDR_CHECK_EN
   logic lat_err;
   assign acc_err = (state == IDLE) ? addr_out_of_range(mem_addr, ADDR_W) : lat_err;
`else
   // Without the check, upper and byte-offset address bits simply alias.
   assign acc_err = 1'b0;
   logic unused_addr_bits;
   assign unused_addr_bits = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
`endif

   assign dbg_rdata = mem[dbg_addr];

   dmem_wait_ctr u_wait_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (accept && (WAIT_CYCLES > 0)),
      .load_val (WAIT_LOAD),
      .dec      (state == WAIT),
      .zero     (ctr_zero)
   );

   // Handshake FSM: latch the request, time the wait, pulse ready once.
   // NOTE: all state here uses <= so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_ready <= 1'b0;
         mem_rdata <= '0;
         busy      <= 1'b0;
         lat_idx   <= '0;
         lat_wen   <= 1'b0;
         lat_wdata <= '0;
`ifdef DMEM_ADDR_CHECK_EN
         lat_err   <= 1'b0;
         mem_err   <= 1'b0;
`endif
      end else begin
         mem_ready <= commit;
`ifdef DMEM_ADDR_CHECK_EN
         mem_err   <= commit && acc_err;
`endif
         case (state)
            IDLE: begin
               if (mem_req) begin
                  lat_idx   <= mem_addr[ADDR_W+1:2];
                  lat_wen   <= mem_wen;
                  lat_wdata <= mem_wdata;
`ifdef DMEM_ADDR_CHECK_EN
                  lat_err   <= acc_err;
`endif
                  busy      <= 1'b1;
                  state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               if (ctr_zero) state <= RESP;
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         if (commit && !acc_wen) begin
            mem_rdata <= acc_err ? '0 : mem[acc_idx];
         end
      end
   end

   // Storage: core write commit, then debug write, so debug wins a collision.
   // NOTE: contents must clear on reset, so this is a flop array, not a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (commit && acc_wen && !acc_err) mem[acc_idx] <= acc_wdata;
         if (dbg_we) mem[dbg_addr] <= dbg_wdata;
      end
   end

endmodule
